rr_lock_arbiter: RTL
====================

RR_LOCK_ARBITER -- requirements
Module: rr_lock_arbiter

Interface
REQ-001 Parameter: Count, default 3, number of requesters; SHALL be >= 2.
REQ-002 Port: clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: valid_i  input  Count  per-requester beat valid.
REQ-005 Port: last_i  input  Count  per-requester final-beat marker, sampled with valid_i.
REQ-006 Port: ready_o  output  Count  per-requester beat accept.
REQ-007 Port: select_o  output  Count  registered one-hot0 grant; drives downstream one-hot mux select.
REQ-008 Port: valid_o  output  1  muxed valid of granted requester.
REQ-009 Port: ready_i  input  1  downstream accept.

Function
REQ-010 State machine SHALL have two states: IDLE (no grant) and LOCKED (one grant held).
REQ-011 select_o SHALL be driven directly from the grant register and SHALL be one-hot0 in every cycle: exactly one bit set in LOCKED, zero bits set in IDLE.
REQ-012 A round-robin pointer, ptr, of width $clog2(Count), SHALL give the highest-priority index; priority descends ptr, ptr+1, ..., wrapping modulo Count.
REQ-013 IDLE, any valid_i bit set: grant the highest-priority set bit at the next edge and enter LOCKED; one cycle arbitration latency.
REQ-014 IDLE, valid_i == 0: remain IDLE.
REQ-015 In IDLE, valid_o, ready_o and select_o SHALL be 0.
REQ-016 LOCKED, granted index g: valid_o = valid_i[g]; ready_o[g] = ready_i; all other ready_o bits 0 (combinational).
REQ-017 A beat SHALL transfer when valid_o && ready_i.
REQ-018 LOCKED, transferred beat without last_i[g]: hold grant; ptr unchanged.
REQ-019 LOCKED, transferred beat with last_i[g] (release):
  - ptr SHALL become (g+1) mod Count;
  - arbitration SHALL be re-run in the same cycle over current valid_i with the new ptr, so index g ranks lowest;
  - any bit set: the new grant loads at the same edge, with no idle cycle between packets;
  - no bit set: enter IDLE.
REQ-020 Grant SHALL hold while valid_i[g] is deasserted mid-packet; other requesters SHALL NOT be granted until g releases.
REQ-021 last_i SHALL be ignored for non-granted indices and for cycles without a transfer.
REQ-022 Single-beat packets (valid_i[g] && last_i[g] on first beat) SHALL release per REQ-019.
REQ-023 Wrap-around: g = Count-1 releasing SHALL set ptr = 0.
REQ-024 valid_i and ready_i SHALL NOT combinationally affect select_o.

Reset
REQ-025 While rst_ni = 0: state IDLE, grant register 0, ptr 0. Therefore select_o = 0, valid_o = 0, ready_o = 0, effective immediately without a clock edge.
REQ-026 Reset asserted mid-packet SHALL drop the grant; the partial packet is abandoned and no beats are accepted until re-arbitration after reset release.
REQ-027 The first arbitration after reset release SHALL use ptr = 0.

Verification (Count = 3)
REQ-028 Reset, then valid_i = 3'b110 at one edge -> select_o = 3'b010 at the next edge; ready_o = 3'b000 in the request cycle.
REQ-029 All three requesting single-beat packets (last_i = 3'b111), ready_i = 1 continuously -> select_o sequence 001, 010, 100, 001, one grant per cycle with no gaps.
REQ-030 Requester 0 sends a 3-beat packet; requester 1 requests from cycle 1; valid_i[0] drops for 2 cycles mid-packet -> select_o stays 001 until beat 3 (last) transfers, then becomes 010 at the next edge.
REQ-031 ready_i = 0 for 4 cycles with the grant on index 2 and valid_i[2] = 1, last_i[2] = 1 -> select_o stays 100, ready_o = 000, ptr unchanged. Then ready_i = 1 -> release, ptr = 0.
REQ-032 rst_ni pulsed low mid-packet on index 1 -> select_o, valid_o, ready_o = 0 asynchronously. After release with valid_i = 3'b111 -> grant 001.
REQ-033 Formal properties: select_o one-hot0 at all times; ready_o subset of select_o; valid_o implies select_o != 0; a granted requester is never switched before its last beat transfers.

Source files
------------

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter with packet lock: a grant is held until the granted
// requester transfers a beat marked last, then the pointer advances past it.
//
// state  | meaning
// IDLE   | no grant held; arbitrate over valid_i with ptr
// LOCKED | one requester granted until its last beat transfers
module rr_lock_arbiter #(
  parameter int Count = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Count-1:0] valid_i,
  input  logic [Count-1:0] last_i,
  output logic [Count-1:0] ready_o,
  output logic [Count-1:0] select_o,
  output logic             valid_o,
  input  logic             ready_i
);

  localparam int PW = $clog2(Count);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state;
  logic [Count-1:0] grant;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    grant_idx;
  logic [PW-1:0]    ptr_rel;
  logic             transfer;
  logic             release_beat;
  logic [Count-1:0] pick_idle;
  logic [Count-1:0] pick_rel;

  // Rotate requests so index 'start' sits at bit 0, isolate the lowest set
  // bit, then rotate the one-hot result back into place.
  function automatic logic [Count-1:0] rr_pick(input logic [Count-1:0] req,
                                               input logic [PW-1:0]    start);
    logic [2*Count-1:0] dbl;
    logic [Count-1:0]   rot;
    logic [Count-1:0]   low;
    dbl = {req, req} >> start;
    rot = dbl[Count-1:0];
    low = rot & (~rot + Count'(1));
    dbl = {low, low} << start;
    return dbl[2*Count-1:Count];
  endfunction

  always_comb begin
    grant_idx = '0;
    for (int j = 0; j < Count; j++) begin
      if (grant[j]) grant_idx = PW'(j);
    end
  end

  assign ptr_rel      = (grant_idx == PW'(Count - 1)) ? '0 : grant_idx + PW'(1);
  assign select_o     = grant;
  assign valid_o      = |(grant & valid_i);
  assign ready_o      = grant & {Count{ready_i}};
  assign transfer     = valid_o & ready_i;
  assign release_beat = transfer & (|(grant & last_i));
  assign pick_idle    = rr_pick(valid_i, ptr);
  assign pick_rel     = rr_pick(valid_i, ptr_rel);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|valid_i) begin
            grant <= pick_idle;
            state <= LOCKED;
          end
        end
        LOCKED: begin
          // Re-arbitrate on release so back-to-back packets need no idle cycle.
          if (release_beat) begin
            ptr <= ptr_rel;
            if (|valid_i) begin
              grant <= pick_rel;
            end else begin
              grant <= '0;
              state <= IDLE;
            end
          end
        end
        default: begin
          grant <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
